// File: rtl/gf233_pkg.sv
// rtl/gf233_pkg.sv - shared GF(2^233) types, constants, FSM state and squaring function
//
// Purpose: common definitions for the GF(2^233) point-arithmetic datapath.
//   Field: polynomial basis, reduction trinomial x^233 + x^74 + 1.
// Contents:
//   M, K, SQRT_ITER   field degree, middle trinomial tap, squarings per sqrt
//   gf233_t           one field element, bit i = coefficient of x^i
//   sqrt_state_t      FSM state of gf233_sqrt_unit
//   gf233_sqr()       combinational modular squaring
package gf233_pkg;

  localparam int M         = 233;
  localparam int K         = 74;
  localparam int SQRT_ITER = 232;

  typedef logic [M-1:0] gf233_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sqrt_state_t;

  // Squaring in characteristic 2 only spreads coefficients to even positions.
  // The 465-bit product is folded top-down with x^i = x^(i-233) * (x^74 + 1);
  // folds into positions >= 233 are handled later in the same descending loop,
  // which gives the two reduction passes.
  function automatic gf233_t gf233_sqr(input gf233_t a);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) begin
      t[2*i] = a[i];
    end
    for (int i = 2*M-2; i >= M; i--) begin
      t[i-M]   = t[i-M]   ^ t[i];
      t[i-M+K] = t[i-M+K] ^ t[i];
    end
    return t[M-1:0];
  endfunction

endpackage

// File: rtl/gf233_sqrt_unit_if.sv
// rtl/gf233_sqrt_unit_if.sv - operand/result handshake bundle of gf233_sqrt_unit
//
// Signals:
//   in_valid/in_ready/din      operand handshake (master -> unit)
//   out_valid/out_ready/dout   result handshake (unit -> master)
//   busy                       unit is in RUN or DONE
//   n_sq                       squaring count, only with GF233_SQRT_MULTISQ_EN
// Modports: master (controller side), slave (unit side).
interface gf233_sqrt_unit_if;

  logic                 in_valid;
  logic                 in_ready;
  gf233_pkg::gf233_t    din;
  logic                 out_valid;
  logic                 out_ready;
  gf233_pkg::gf233_t    dout;
  logic                 busy;

`ifdef GF233_SQRT_MULTISQ_EN
  logic [7:0]           n_sq;

  modport master (
    output in_valid, din, out_ready, n_sq,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, out_ready, n_sq,
    output in_ready, out_valid, dout, busy
  );
`else
  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, busy
  );
`endif

endinterface

// File: rtl/gf233_sqr_chain.sv
// rtl/gf233_sqr_chain.sv - combinational cascade of SQ_PER_CYC modular squarers
//
// Ports:
//   din    in   element to be squared repeatedly
//   taps   out  taps[j] = din^(2^j), j = 0..SQ_PER_CYC
module gf233_sqr_chain
  import gf233_pkg::*;
#(
  parameter int SQ_PER_CYC = 8
) (
  input  gf233_t                  din,
  output gf233_t [SQ_PER_CYC:0]   taps
);

  assign taps[0] = din;

  for (genvar j = 0; j < SQ_PER_CYC; j++) begin : g_sq
    assign taps[j+1] = gf233_sqr(taps[j]);
  end

endmodule

// File: rtl/gf233_sqrt_unit.sv
// rtl/gf233_sqrt_unit.sv - sequential GF(2^233) square root by iterated squaring
//
// Computes sqrt(a) = a^(2^232), applying SQ_PER_CYC squarings per RUN cycle.
// Optional feature macro: GF233_SQRT_MULTISQ_EN -- computes a^(2^n_sq) instead,
// with n_sq sampled when the operand is accepted.
//
// Parameters:
//   SQ_PER_CYC   squarings per RUN cycle, must divide 232 (1, 2, 4, 8, 29, 58)
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   bus          gf233_sqrt_unit_if.slave (operand/result handshake, busy)
module gf233_sqrt_unit
  import gf233_pkg::*;
#(
  parameter int SQ_PER_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  gf233_sqrt_unit_if.slave  bus
);

  localparam int STEPS = SQRT_ITER / SQ_PER_CYC;

`ifdef GF233_SQRT_MULTISQ_EN
  // Counts remaining squarings, so it must hold any n_sq value.
  localparam int CNT_W = 8;
`else
  // Counts remaining RUN cycles.
  localparam int CNT_W = $clog2(STEPS + 1);
`endif

  sqrt_state_t              state;
  gf233_t                   r;
  logic [CNT_W-1:0]         cnt;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     busy_q;

  gf233_t [SQ_PER_CYC:0]    taps;
  gf233_t                   r_next;
  logic [CNT_W-1:0]         step;
  logic                     last_step;

  gf233_sqr_chain #(
    .SQ_PER_CYC (SQ_PER_CYC)
  ) u_chain (
    .din  (r),
    .taps (taps)
  );

`ifdef GF233_SQRT_MULTISQ_EN
  // Final cycle may need fewer than SQ_PER_CYC squarings: pick tap min(SQ, cnt).
  always_comb begin
    r_next = taps[SQ_PER_CYC];
    step   = CNT_W'(SQ_PER_CYC);
    for (int j = 1; j < SQ_PER_CYC; j++) begin
      if (cnt == CNT_W'(j)) begin
        r_next = taps[j];
        step   = CNT_W'(j);
      end
    end
  end

  assign last_step = (cnt <= CNT_W'(SQ_PER_CYC));
`else
  // Only the full-depth tap is used when the count is fixed.
  logic unused_taps;
  assign unused_taps = ^taps[SQ_PER_CYC-1:0];

  assign r_next    = taps[SQ_PER_CYC];
  assign step      = CNT_W'(1);
  assign last_step = (cnt == CNT_W'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      r           <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // in_ready rises on the first edge after reset release.
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            r          <= bus.din;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef GF233_SQRT_MULTISQ_EN
            cnt <= bus.n_sq;
            if (bus.n_sq == 8'd0) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
`else
            cnt   <= CNT_W'(STEPS);
            state <= ST_RUN;
`endif
          end
        end

        ST_RUN: begin
          r   <= r_next;
          cnt <= cnt - step;
          if (last_step) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end

        ST_DONE: begin
          // Returning to IDLE with in_ready already high gives a one-cycle gap
          // between taking a result and accepting the next operand.
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.dout      = r;

endmodule
